// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - packs a byte stream into weight words and writes them to the weight medium
module weight_loader #(
    parameter  int ADDRS      = 256,
    parameter  int BRAM_WIDTH = 64,
    parameter  int PIECES     = 48,
    parameter  int BYTE_WIDTH = 8,
    localparam int ADDR_SIZE  = $clog2(ADDRS),
    localparam int WIDTH      = PIECES * BRAM_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_SIZE-1:0]  base_addr_in,
    input  logic [ADDR_SIZE:0]    count_in,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid_in,
    output logic                  byte_ready_out,
    output logic [ADDR_SIZE-1:0]  addr_out,
    output logic [WIDTH-1:0]      weight_out,
    output logic                  write_enable_out,
    input  logic                  finished_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ADDR_SIZE:0]    words_written_out
);

    localparam int BEATS  = WIDTH / BYTE_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(ADDRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE:0]     count_q, count_d;
    logic [ADDR_SIZE:0]     words_q, words_d;
    logic [ADDR_SIZE:0]     words_inc;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [WIDTH-1:0]       weight_q, weight_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            words_q  <= '0;
            beat_q   <= '0;
            weight_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            words_q  <= words_d;
            beat_q   <= beat_d;
            weight_q <= weight_d;
        end
    end

    assign words_inc = words_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        words_d  = words_q;
        beat_d   = beat_q;
        weight_d = weight_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    addr_d  = base_addr_in;
                    count_d = count_in;
                    words_d = '0;
                    beat_d  = '0;
                    state_d = (count_in == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_valid_in) begin
                    // Decoded lane write keeps the byte placement little-endian without a variable shifter.
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_q == BEAT_W'(k)) begin
                            weight_d[k*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (finished_in) begin
                    words_d = words_inc;
                    addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    state_d = (words_inc == count_q) ? S_DONE : S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_ready_out    = (state_q == S_COLLECT);
    assign write_enable_out  = (state_q == S_WRITE);
    assign busy_out          = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_WAIT);
    assign done_out          = (state_q == S_DONE);
    assign addr_out          = addr_q;
    assign weight_out        = weight_q;
    assign words_written_out = words_q;

endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - scoreboard bench for weight_loader in the small configuration
module tb_weight_loader;

    localparam int ADDRS      = 4;
    localparam int BRAM_WIDTH = 8;
    localparam int PIECES     = 2;
    localparam int BYTE_WIDTH = 8;
    localparam int AW         = $clog2(ADDRS);
    localparam int W          = PIECES * BRAM_WIDTH;
    localparam int BEATS      = W / BYTE_WIDTH;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  start_in;
    logic [AW-1:0]         base_addr_in;
    logic [AW:0]           count_in;
    logic [BYTE_WIDTH-1:0] byte_in;
    logic                  byte_valid_in;
    logic                  byte_ready_out;
    logic [AW-1:0]         addr_out;
    logic [W-1:0]          weight_out;
    logic                  write_enable_out;
    logic                  finished_in;
    logic                  busy_out;
    logic                  done_out;
    logic [AW:0]           words_written_out;

    int  checks   = 0;
    int  errors   = 0;
    int  done_cnt = 0;
    int  fin_delay = 3;
    int  gen      = 0;
    wr_t sb[$];

    bit            in_wait   = 0;
    bit            fin_seen  = 0;
    bit            prev_done = 0;
    logic [AW-1:0] cap_addr;
    logic [W-1:0]  cap_w;

    always #5 clk_in = ~clk_in;

    weight_loader #(
        .ADDRS(ADDRS), .BRAM_WIDTH(BRAM_WIDTH), .PIECES(PIECES), .BYTE_WIDTH(BYTE_WIDTH)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .base_addr_in(base_addr_in), .count_in(count_in),
        .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
        .addr_out(addr_out), .weight_out(weight_out), .write_enable_out(write_enable_out),
        .finished_in(finished_in), .busy_out(busy_out), .done_out(done_out),
        .words_written_out(words_written_out)
    );

    // Medium model: answers each write with a finished pulse fin_delay cycles later, unless a reset intervened.
    initial begin
        finished_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst_in && write_enable_out) begin
                int g;
                g = gen;
                repeat (fin_delay) @(posedge clk_in);
                #1;
                if (g == gen) begin
                    finished_in = 1'b1;
                    @(posedge clk_in);
                    #1;
                    finished_in = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            in_wait   = 0;
            fin_seen  = 0;
            prev_done = 0;
        end else begin
            if (fin_seen) begin
                fin_seen = 0;
                in_wait  = 0;
                checks++;
                if (sb.size() == 0) begin
                    if (done_out !== 1'b1) begin
                        errors++;
                        $display("FAIL done_latency: done_out=%b required 1", done_out);
                    end
                end else if (byte_ready_out !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_latency: byte_ready_out=%b required 1", byte_ready_out);
                end
            end else if (in_wait) begin
                checks++;
                if (byte_ready_out !== 1'b0 || write_enable_out !== 1'b0 ||
                    addr_out !== cap_addr || weight_out !== cap_w) begin
                    errors++;
                    $display("FAIL wait_stable: ready=%b we=%b addr=%h weight=%h required ready=0 we=0 addr=%h weight=%h",
                             byte_ready_out, write_enable_out, addr_out, weight_out, cap_addr, cap_w);
                end
                if (finished_in) fin_seen = 1;
            end
            if (write_enable_out) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h weight=%h required no write", addr_out, weight_out);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (addr_out !== e.addr || weight_out !== e.data) begin
                        errors++;
                        $display("FAIL write: addr=%h weight=%h required addr=%h weight=%h",
                                 addr_out, weight_out, e.addr, e.data);
                    end
                end
                cap_addr = addr_out;
                cap_w    = weight_out;
                in_wait  = 1;
            end
            if (done_out) begin
                done_cnt++;
                checks++;
                if (prev_done || busy_out !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: prev_done=%b busy=%b required prev_done=0 busy=0", prev_done, busy_out);
                end
            end
            prev_done = done_out;
        end
    end

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (byte_ready_out !== 1'b0 || addr_out !== '0 || weight_out !== '0 || write_enable_out !== 1'b0 ||
            busy_out !== 1'b0 || done_out !== 1'b0 || words_written_out !== '0) begin
            errors++;
            $display("FAIL %s: ready=%b addr=%h weight=%h we=%b busy=%b done=%b words=%0d required all 0",
                     tag, byte_ready_out, addr_out, weight_out, write_enable_out, busy_out, done_out, words_written_out);
        end
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] c);
        base_addr_in = b;
        count_in     = c;
        start_in     = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rnd);
        for (int k = 0; k < BEATS; k++) begin
            int guard;
            bit taken;
            guard   = 0;
            taken   = 0;
            byte_in = w[k*BYTE_WIDTH +: BYTE_WIDTH];
            while (!taken) begin
                byte_valid_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk_in);
                taken = byte_valid_in && byte_ready_out;
                @(posedge clk_in);
                #1;
                guard++;
                if (guard > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", k, guard);
                    byte_valid_in = 1'b0;
                    return;
                end
            end
        end
        byte_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < 300) begin
            @(negedge clk_in);
            guard++;
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL done_count: done pulses=%0d required %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic run_job(input logic [AW-1:0] base, input logic [AW:0] count,
                           input logic [W-1:0] words[$], input bit rnd);
        int  d0;
        wr_t e;
        d0 = done_cnt;
        for (int i = 0; i < int'(count); i++) begin
            e.addr = AW'((int'(base) + i) % ADDRS);
            e.data = words[i];
            sb.push_back(e);
        end
        start_job(base, count);
        for (int i = 0; i < int'(count); i++) send_word(words[i], rnd);
        wait_done(d0);
        checks++;
        if (words_written_out !== count) begin
            errors++;
            $display("FAIL words_written: got=%0d required %0d", words_written_out, count);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL writes_missing: outstanding=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_in        = 1'b1;
        start_in      = 1'b0;
        base_addr_in  = '0;
        count_in      = '0;
        byte_in       = '0;
        byte_valid_in = 1'b0;
        #1;
        rst_in = 1'b0;
        #2;
        check_outputs_zero("reset_state");
        repeat (3) @(posedge clk_in);
        #1;
        check_outputs_zero("reset_held");
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_basic();
        logic [W-1:0] q[$];
        fin_delay = 3;
        q.push_back(16'h2211);
        q.push_back(16'h4433);
        run_job(2'd1, 3'd2, q, 1'b0);
    endtask

    task automatic test_wrap();
        logic [W-1:0] q[$];
        fin_delay = 3;
        q.push_back(W'($urandom));
        q.push_back(W'($urandom));
        run_job(2'd3, 3'd2, q, 1'b0);
    endtask

    task automatic test_empty();
        int d0;
        bit bad;
        d0 = done_cnt;
        bad = 0;
        start_job(2'd2, 3'd0);
        @(negedge clk_in);
        checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: done=%b busy=%b required done=1 busy=0", done_out, busy_out);
        end
        checks++;
        if (words_written_out !== '0) begin
            errors++;
            $display("FAIL empty_words: got=%0d required 0", words_written_out);
        end
        for (int i = 0; i < 8; i++) begin
            if (byte_ready_out !== 1'b0 || write_enable_out !== 1'b0) bad = 1;
            @(negedge clk_in);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL empty_quiet: ready or write_enable seen high, required both 0");
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL empty_done_count: got=%0d required %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q[$];
        fin_delay = 10;
        for (int i = 0; i < ADDRS; i++) q.push_back(W'($urandom));
        run_job(2'd2, 3'd4, q, 1'b1);
    endtask

    task automatic test_busy_restart();
        logic [W-1:0] w;
        wr_t e;
        int  d0;
        bit  bad;
        fin_delay = 3;
        w = W'($urandom);
        e.addr = 2'd2;
        e.data = w;
        sb.push_back(e);
        d0 = done_cnt;
        start_job(2'd2, 3'd1);
        start_job(2'd0, 3'd4);
        send_word(w, 1'b0);
        start_job(2'd0, 3'd4);
        wait_done(d0);
        checks++;
        if (words_written_out !== 3'd1) begin
            errors++;
            $display("FAIL restart_words: got=%0d required 1", words_written_out);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (byte_ready_out !== 1'b0 || busy_out !== 1'b0) bad = 1;
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL restart_idle: loader went busy after job end, required idle");
        end
    endtask

    task automatic test_midjob_reset();
        logic [W-1:0] w;
        logic [W-1:0] q[$];
        wr_t e;
        int  d0;
        fin_delay = 10;
        w = W'($urandom);
        e.addr = 2'd1;
        e.data = w;
        sb.push_back(e);
        d0 = done_cnt;
        start_job(2'd1, 3'd1);
        send_word(w, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (busy_out !== 1'b1 || write_enable_out !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait: busy=%b we=%b required busy=1 we=0", busy_out, write_enable_out);
        end
        rst_in = 1'b0;
        gen++;
        #1;
        check_outputs_zero("midjob_reset");
        sb.delete();
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        repeat (12) @(posedge clk_in);
        #1;
        checks++;
        if (done_cnt !== d0 || words_written_out !== '0) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d words=%0d required 0 and 0", done_cnt - d0, words_written_out);
        end
        fin_delay = 3;
        q.push_back(W'($urandom));
        run_job(2'd0, 3'd1, q, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_backpressure();
        test_busy_restart();
        test_midjob_reset();
        repeat (4) @(posedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream feeder for the weight store.
- Accepts a byte stream from the host link (valid/ready) and packs it into full-width weight words.
- Writes each word into the weight medium through its write_enable/finished handshake, at consecutive addresses from a programmed base.
- Used at boot and on reload to fill the weight store before inference starts.

Parameters:
- ADDRS, 256, number of weight words in the store; ADDR_SIZE = $clog2(ADDRS).
- BRAM_WIDTH, 64, width of one BRAM piece.
- PIECES, 48, BRAM pieces per weight word; WIDTH = PIECES*BRAM_WIDTH.
- BYTE_WIDTH, 8, width of one stream beat. WIDTH must be a multiple of BYTE_WIDTH; BEATS = WIDTH/BYTE_WIDTH.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  one-cycle pulse; begins a load job. Ignored unless state is IDLE.
- base_addr_in  input  ADDR_SIZE  first weight address, sampled on start_in.
- count_in  input  ADDR_SIZE+1  number of words to load, 0..ADDRS, sampled on start_in.
- byte_in  input  BYTE_WIDTH  stream data.
- byte_valid_in  input  1  stream data valid.
- byte_ready_out  output  1  loader accepts a beat this cycle.
- addr_out  output  ADDR_SIZE  to medium addr_in.
- weight_out  output  WIDTH  to medium weight_in.
- write_enable_out  output  1  to medium write_enable.
- finished_in  input  1  from medium finished_out.
- busy_out  output  1  a job is in progress.
- done_out  output  1  one-cycle pulse at job end.
- words_written_out  output  ADDR_SIZE+1  words completed in the current or last job.

Behaviour:
- Reset (rst_in=0, async): state IDLE; all outputs 0, including weight_out, addr_out and words_written_out; byte counter 0.
- Beat transfer: occurs on a rising edge with byte_valid_in & byte_ready_out. byte_ready_out is 1 only in COLLECT and is combinational on state only, never on byte_valid_in.
- Packing:
  - Beat k (0..BEATS-1) of a word lands in weight_out[k*BYTE_WIDTH +: BYTE_WIDTH], little-endian.
  - Unwritten bits keep their previous value and are fully overwritten before use.
- States:
  - IDLE: busy_out=0. On start_in, latch base/count, clear words_written_out and the beat counter. Go to COLLECT if count_in!=0. If count_in==0, go to DONE.
  - COLLECT: busy_out=1. On accepting beat BEATS-1, go to WRITE on the next cycle; the beat counter returns to 0.
  - WRITE: exactly one cycle with write_enable_out=1. addr_out = current address; weight_out holds the packed word. Next state is WAIT.
  - WAIT: write_enable_out=0; weight_out and addr_out stay stable. On finished_in=1:
    - increment words_written_out;
    - advance the address modulo ADDRS (ADDRS-1 wraps to 0);
    - if words_written_out+1 == count, go to DONE, else go to COLLECT.
  - finished_in outside WAIT is ignored.
  - DONE: one cycle with done_out=1 and busy_out=0, then IDLE. words_written_out holds until the next start_in.
- Latency:
  - Last beat to write_enable_out is exactly 1 cycle.
  - finished_in to byte_ready_out=1 for the next word is 1 cycle.
  - Final finished_in to done_out is 1 cycle.
- start_in while busy is ignored: latched base/count are unchanged and no error is flagged.
- Async reset mid-job aborts immediately: no done_out and no partial write. A write already issued to the medium is the medium's concern.
- Stream stalls (byte_valid_in=0) in COLLECT hold state indefinitely; there is no timeout.

Test Plan:
1. Small configuration (ADDRS=4, BRAM_WIDTH=8, PIECES=2, BEATS=2):
   - Stimulus: start base=1, count=2; beats 0x11,0x22,0x33,0x44; finished_in pulsed 3 cycles after each write_enable.
   - Required: writes 0x2211 to addr 1 and 0x4433 to addr 2; one write_enable cycle per word; done_out 1 cycle after the second finished_in; words_written_out=2.
2. Same configuration, address wrap:
   - Stimulus: base=3, count=2.
   - Required: writes to addr 3 then addr 0.
3. Empty job:
   - Stimulus: count=0.
   - Required: done_out 1 cycle after start, no write_enable, byte_ready_out never 1.
4. Backpressure:
   - Stimulus: byte_valid_in toggled randomly; finished_in delayed 10 cycles.
   - Required: byte_ready_out=0 from WRITE until 1 cycle after finished_in; weight_out/addr_out stable in WAIT; data intact.
5. Busy restart:
   - Stimulus: second start_in (base=0, count=4) during a count=1 job.
   - Required: ignored; only 1 word written, at the original base.
6. Mid-job reset:
   - Stimulus: rst_in low in WAIT, then start base=0, count=1.
   - Required: all outputs 0 immediately, no done_out, next job completes normally.
